// File: rtl/wb_stage_pipe_pkg.sv
// Shared encodings for the MIPS write-back stage: result-source select,
// load size, and the sub-word extension helper.
package wb_stage_pipe_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10
  } wb_sel_t;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10
  } ld_size_t;

  // Extends a half (val[15:0]) or byte (val[7:0]) to 32 bits.
  function automatic logic [31:0] sub_extend(input logic [15:0] val,
                                             input logic        is_half,
                                             input logic        zext);
    logic fill;
    fill = ~zext & (is_half ? val[15] : val[7]);
    return is_half ? {{16{fill}}, val} : {{24{fill}}, val[7:0]};
  endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM->WB bundle: pipeline control, MEM/WB latch inputs and the registered
// write-back results.
interface wb_stage_pipe_if #(
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 32
);
  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic                  in_regwrite;
  logic [1:0]            in_wb_sel;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [31:0]           in_alu_result;
  logic [31:0]           in_read_data;
  logic [31:0]           in_link_addr;
  logic [1:0]            in_load_size;
  logic                  in_load_unsigned;

  logic [31:0]           wb_data;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_regwrite;
  logic                  wb_valid;
  logic [COUNT_W-1:0]    retired_count;

  modport master (
    output stall, flush, in_valid, in_regwrite, in_wb_sel, in_rd,
           in_alu_result, in_read_data, in_link_addr, in_load_size,
           in_load_unsigned,
    input  wb_data, wb_rd, wb_regwrite, wb_valid, retired_count
  );

  modport slave (
    input  stall, flush, in_valid, in_regwrite, in_wb_sel, in_rd,
           in_alu_result, in_read_data, in_link_addr, in_load_size,
           in_load_unsigned,
    output wb_data, wb_rd, wb_regwrite, wb_valid, retired_count
  );
endinterface

// File: rtl/wb_stage_pipe_load_align.sv
// Combinational lane select and sign/zero extension for sub-word loads.
module load_align
  import wb_stage_pipe_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_off,
  input  ld_size_t    i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // Physical byte lane (0 = bits [7:0]); the half lane is its upper bit,
    // which makes the half select ignore off[0] for both byte orders.
    w_lane = (BIG_ENDIAN != 0) ? ~i_off : i_off;
    case (w_lane)
      2'd0:    w_byte = i_raw[7:0];
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      default: w_byte = i_raw[31:24];
    endcase
    w_half = w_lane[1] ? i_raw[31:16] : i_raw[15:0];

    case (i_size)
      LD_HALF: o_data = sub_extend(w_half, 1'b1, i_unsigned);
      LD_BYTE: o_data = sub_extend({8'h00, w_byte}, 1'b0, i_unsigned);
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB latch and write-back select for the 5-stage MIPS pipeline, with
// stall/flush, $0 write suppression and a retired-instruction counter.
module wb_stage_pipe
  import wb_stage_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int ZERO_GUARD = 1
) (
  input logic             clk,
  input logic             rst,
  wb_stage_pipe_if.slave  bus
);

  logic [31:0]           r_data;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_regwrite;
  logic                  r_valid;
  logic [COUNT_W-1:0]    r_count;

  wb_sel_t               w_sel;
  ld_size_t              w_size;
  logic [31:0]           w_load_data;
  logic [31:0]           w_sel_data;
  logic                  w_rd_is_zero;
  logic                  w_regwrite;

  assign w_size = ld_size_t'(bus.in_load_size);

  load_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_load_align (
    .i_raw      (bus.in_read_data),
    .i_off      (bus.in_alu_result[1:0]),
    .i_size     (w_size),
    .i_unsigned (bus.in_load_unsigned),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_sel = wb_sel_t'(bus.in_wb_sel);
    case (w_sel)
      WB_SEL_MEM:  w_sel_data = w_load_data;
      WB_SEL_LINK: w_sel_data = bus.in_link_addr;
      default:     w_sel_data = bus.in_alu_result;
    endcase
    w_rd_is_zero = (bus.in_rd == '0);
    w_regwrite   = bus.in_valid & bus.in_regwrite &
                   ~((ZERO_GUARD != 0) & w_rd_is_zero);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_valid    <= 1'b0;
      r_count    <= '0;
    end else if (bus.flush) begin
      // Bubble: data/rd keep their old value, only the qualifiers drop.
      r_regwrite <= 1'b0;
      r_valid    <= 1'b0;
    end else if (!bus.stall) begin
      r_data     <= w_sel_data;
      r_rd       <= bus.in_rd;
      r_regwrite <= w_regwrite;
      r_valid    <= bus.in_valid;
      if (bus.in_valid) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign bus.wb_data       = r_data;
  assign bus.wb_rd         = r_rd;
  assign bus.wb_regwrite   = r_regwrite;
  assign bus.wb_valid      = r_valid;
  assign bus.retired_count = r_count;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: big-endian 32-bit-counter instance for
// the main table and stall/flush/reset sequences, little-endian 4-bit-counter
// instance for byte order and counter wrap.
module tb_wb_stage_pipe;
  import wb_stage_pipe_pkg::*;

  typedef struct {
    logic        st, fl, va, rw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, link;
    logic [1:0]  size;
    logic        uns;
    logic        chk_dr;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_rw, e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  localparam logic [31:0] RD = 32'h80F1_7F02;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nvalid;
  vec_t vecs[19];

  wb_stage_pipe_if #(.REG_ADDR_W(5), .COUNT_W(32)) bus_a ();
  wb_stage_pipe_if #(.REG_ADDR_W(5), .COUNT_W(4))  bus_b ();

  wb_stage_pipe #(
    .REG_ADDR_W (5),
    .COUNT_W    (32),
    .BIG_ENDIAN (1),
    .ZERO_GUARD (1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  wb_stage_pipe #(
    .REG_ADDR_W (5),
    .COUNT_W    (4),
    .BIG_ENDIAN (0),
    .ZERO_GUARD (1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic st, fl, va, rw,
                              input logic [1:0] sel, input logic [4:0] rd,
                              input logic [31:0] alu, rdata, link,
                              input logic [1:0] size, input logic uns,
                              input logic chk_dr, input logic [31:0] e_data,
                              input logic [4:0] e_rd, input logic e_rw, e_valid,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.st = st; v.fl = fl; v.va = va; v.rw = rw; v.sel = sel; v.rd = rd;
    v.alu = alu; v.rdata = rdata; v.link = link; v.size = size; v.uns = uns;
    v.chk_dr = chk_dr; v.e_data = e_data; v.e_rd = e_rd; v.e_rw = e_rw;
    v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.stall            = v.st;
    bus_a.flush            = v.fl;
    bus_a.in_valid         = v.va;
    bus_a.in_regwrite      = v.rw;
    bus_a.in_wb_sel        = v.sel;
    bus_a.in_rd            = v.rd;
    bus_a.in_alu_result    = v.alu;
    bus_a.in_read_data     = v.rdata;
    bus_a.in_link_addr     = v.link;
    bus_a.in_load_size     = v.size;
    bus_a.in_load_unsigned = v.uns;
  endtask

  task automatic set_a(input logic st, fl, va, input logic [4:0] rd, input logic [31:0] alu);
    drive_a(mk(st, fl, va, 1'b1, WB_SEL_ALU, rd, alu, RD, 32'h0, LD_WORD, 1'b0,
               1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0));
  endtask

  task automatic set_b(input logic va, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [1:0] size, input logic uns);
    bus_b.stall            = 1'b0;
    bus_b.flush            = 1'b0;
    bus_b.in_valid         = va;
    bus_b.in_regwrite      = 1'b1;
    bus_b.in_wb_sel        = sel;
    bus_b.in_rd            = 5'd3;
    bus_b.in_alu_result    = alu;
    bus_b.in_read_data     = RD;
    bus_b.in_link_addr     = 32'h0;
    bus_b.in_load_size     = size;
    bus_b.in_load_unsigned = uns;
  endtask

  task automatic check_a(input string tag, input logic chk_dr, input logic [31:0] e_data,
                         input logic [4:0] e_rd, input logic e_rw, e_valid,
                         input logic [31:0] e_cnt);
    if (chk_dr) begin
      chk({tag, ".wb_data"}, bus_a.wb_data, e_data);
      chk({tag, ".wb_rd"}, 32'(bus_a.wb_rd), 32'(e_rd));
    end
    chk({tag, ".wb_regwrite"}, 32'(bus_a.wb_regwrite), 32'(e_rw));
    chk({tag, ".wb_valid"}, 32'(bus_a.wb_valid), 32'(e_valid));
    chk({tag, ".retired_count"}, bus_a.retired_count, e_cnt);
  endtask

  initial begin
    //         st fl va rw sel          rd  alu             rdata link           size     uns chk data          rd rw v cnt
    vecs[0]  = mk(0, 0, 1, 1, WB_SEL_ALU,  8, 32'h0000_1234, RD, 32'h0,          LD_WORD, 0, 1, 32'h0000_1234, 8, 1, 1, 1);
    vecs[1]  = mk(0, 0, 1, 1, WB_SEL_LINK, 8, 32'h0000_5555, RD, 32'h0040_0010,  LD_WORD, 0, 1, 32'h0040_0010, 8, 1, 1, 2);
    vecs[2]  = mk(0, 0, 1, 1, 2'b11,       8, 32'hDEAD_BEEF, RD, 32'h0000_0001,  LD_WORD, 0, 1, 32'hDEAD_BEEF, 8, 1, 1, 3);
    vecs[3]  = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0000, RD, 32'h0,          LD_BYTE, 0, 1, 32'hFFFF_FF80, 9, 1, 1, 4);
    vecs[4]  = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0000, RD, 32'h0,          LD_BYTE, 1, 1, 32'h0000_0080, 9, 1, 1, 5);
    vecs[5]  = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0002, RD, 32'h0,          LD_BYTE, 0, 1, 32'h0000_007F, 9, 1, 1, 6);
    vecs[6]  = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0002, RD, 32'h0,          LD_HALF, 0, 1, 32'h0000_7F02, 9, 1, 1, 7);
    vecs[7]  = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0000, RD, 32'h0,          LD_HALF, 0, 1, 32'hFFFF_80F1, 9, 1, 1, 8);
    vecs[8]  = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0000, RD, 32'h0,          LD_HALF, 1, 1, 32'h0000_80F1, 9, 1, 1, 9);
    vecs[9]  = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0003, RD, 32'h0,          LD_WORD, 0, 1, RD,            9, 1, 1, 10);
    vecs[10] = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0001, RD, 32'h0,          LD_BYTE, 0, 1, 32'hFFFF_FFF1, 9, 1, 1, 11);
    vecs[11] = mk(0, 0, 1, 1, WB_SEL_MEM,  9, 32'h1000_0003, RD, 32'h0,          LD_BYTE, 0, 1, 32'h0000_0002, 9, 1, 1, 12);
    vecs[12] = mk(0, 0, 1, 1, WB_SEL_ALU,  0, 32'h0000_0077, RD, 32'h0,          LD_WORD, 0, 1, 32'h0000_0077, 0, 0, 1, 13);
    vecs[13] = mk(0, 0, 0, 1, WB_SEL_ALU,  9, 32'h0000_0099, RD, 32'h0,          LD_WORD, 0, 1, 32'h0000_0099, 9, 0, 0, 13);
    vecs[14] = mk(0, 0, 1, 0, WB_SEL_ALU, 10, 32'h0000_00AA, RD, 32'h0,          LD_WORD, 0, 1, 32'h0000_00AA, 10, 0, 1, 14);
    vecs[15] = mk(0, 0, 1, 1, WB_SEL_MEM, 11, 32'h1000_0001, RD, 32'h0,          2'b11,   1, 1, RD,            11, 1, 1, 15);
    vecs[16] = mk(0, 0, 1, 1, WB_SEL_ALU, 11, 32'h1234_5679, RD, 32'h0,          LD_BYTE, 0, 1, 32'h1234_5679, 11, 1, 1, 16);
    vecs[17] = mk(0, 1, 1, 1, WB_SEL_ALU,  5, 32'h0000_0005, RD, 32'h0,          LD_WORD, 0, 0, 32'h0,         0, 0, 0, 16);
    vecs[18] = mk(0, 0, 1, 1, WB_SEL_MEM, 11, 32'h1000_0003, RD, 32'h0,          LD_HALF, 0, 1, 32'h0000_7F02, 11, 1, 1, 17);

    rst = 1'b1;
    set_a(0, 0, 0, 5'd0, 32'h0);
    set_b(0, WB_SEL_ALU, 32'h0, LD_WORD, 0);
    #12;
    check_a("reset", 1, 32'h0, 5'd0, 0, 0, 32'h0);
    chk("reset_b.retired_count", 32'(bus_b.retired_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) begin
      set_a(0, 0, 1, 5'd1, 32'h100 + 32'(k));
      step();
    end
    check_a("pre_reset", 1, 32'h106, 5'd1, 1, 1, 32'd7);
    #3 rst = 1'b1;
    #1 check_a("async_reset", 1, 32'h0, 5'd0, 0, 0, 32'h0);
    set_a(0, 0, 0, 5'd0, 32'h0);
    #2 rst = 1'b0;
    step();
    check_a("post_reset", 1, 32'h0, 5'd0, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      drive_a(vecs[i]);
      step();
      check_a($sformatf("vec%0d", i), vecs[i].chk_dr, vecs[i].e_data, vecs[i].e_rd,
              vecs[i].e_rw, vecs[i].e_valid, vecs[i].e_cnt);
    end

    set_a(0, 0, 1, 5'd12, 32'hCAFE_0001);
    step();
    check_a("pre_stall", 1, 32'hCAFE_0001, 5'd12, 1, 1, 32'd18);
    for (int k = 0; k < 3; k++) begin
      set_a(1, 0, 1, 5'd13 + 5'(k), 32'h1111_1111 * 32'(k + 1));
      step();
      check_a($sformatf("stall%0d", k), 1, 32'hCAFE_0001, 5'd12, 1, 1, 32'd18);
    end
    set_a(0, 0, 1, 5'd20, 32'hBEEF_0000);
    step();
    check_a("stall_release", 1, 32'hBEEF_0000, 5'd20, 1, 1, 32'd19);
    set_a(1, 1, 1, 5'd7, 32'h0000_0777);
    step();
    check_a("stall_flush", 0, 32'h0, 5'd0, 0, 0, 32'd19);
    set_a(0, 0, 1, 5'd21, 32'h0000_0021);
    step();
    check_a("after_flush", 1, 32'h0000_0021, 5'd21, 1, 1, 32'd20);
    set_a(0, 0, 0, 5'd0, 32'h0);

    // Little-endian lanes on instance B (5 retirements).
    set_b(1, WB_SEL_MEM, 32'h0, LD_BYTE, 0);
    step(); chk("le_lb0", bus_b.wb_data, 32'h0000_0002);
    set_b(1, WB_SEL_MEM, 32'h3, LD_BYTE, 0);
    step(); chk("le_lb3", bus_b.wb_data, 32'hFFFF_FF80);
    set_b(1, WB_SEL_MEM, 32'h0, LD_HALF, 0);
    step(); chk("le_lh0", bus_b.wb_data, 32'h0000_7F02);
    set_b(1, WB_SEL_MEM, 32'h2, LD_HALF, 0);
    step(); chk("le_lh2", bus_b.wb_data, 32'hFFFF_80F1);
    set_b(1, WB_SEL_MEM, 32'h1, LD_BYTE, 1);
    step(); chk("le_lbu1", bus_b.wb_data, 32'h0000_007F);
    chk("le.retired_count", 32'(bus_b.retired_count), 32'd5);

    nvalid = 5;
    for (int j = 0; j < 15; j++) begin
      if (j == 3 || j == 7 || j == 11) begin
        set_b(0, WB_SEL_ALU, 32'(j), LD_WORD, 0);
      end else begin
        set_b(1, WB_SEL_ALU, 32'(j), LD_WORD, 0);
        nvalid++;
      end
      step();
      if (nvalid == 16 && bus_b.in_valid) begin
        chk("wrap_zero", 32'(bus_b.retired_count), 32'd0);
      end
    end
    chk("wrap_total", 32'(nvalid), 32'd17);
    chk("wrap.retired_count", 32'(bus_b.retired_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered write-back stage for the 5-stage MIPS pipeline.
- Absorbs the MEM/WB latch and selects among ALU result, memory load data and link address.
- Aligns and sign- or zero-extends sub-word loads, supports stall and flush, and suppresses writes to $0.
- Counts retired instructions. Outputs drive the write port of the register file in I_DECODE and the forwarding unit.

Parameters:
- REG_ADDR_W, 5, width of the destination register index.
- COUNT_W, 32, width of the retired-instruction counter.
- BIG_ENDIAN, 1, byte-lane order for sub-word loads: 1 means offset 0 is bits [31:24]; 0 means offset 0 is bits [7:0].
- ZERO_GUARD, 1, when 1 a write to register index 0 is forced to wb_regwrite=0.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold all registered outputs and the counter.
- flush  input  1  insert a bubble.
- in_valid  input  1  MEM stage holds a real instruction.
- in_regwrite  input  1  instruction writes the register file.
- in_wb_sel  input  2  source select: 00 ALU, 01 MEM, 10 LINK, 11 treated as ALU.
- in_rd  input  REG_ADDR_W  destination register.
- in_alu_result  input  32  ALU result; also the load address, bits [1:0] used as the byte offset.
- in_read_data  input  32  raw word from data memory.
- in_link_addr  input  32  PC+8 for jal/jalr.
- in_load_size  input  2  00 word, 01 half, 10 byte, 11 treated as word.
- in_load_unsigned  input  1  zero-extend sub-word loads (lbu/lhu).
- wb_data  output  32  registered write-back data.
- wb_rd  output  REG_ADDR_W  registered destination.
- wb_regwrite  output  1  registered write enable.
- wb_valid  output  1  registered instruction-valid flag.
- retired_count  output  COUNT_W  number of valid instructions retired.

Behaviour:
- Reset (async, rst=1): wb_data=0, wb_rd=0, wb_regwrite=0, wb_valid=0, retired_count=0. Reset takes effect immediately mid-operation; the first capture is on the first rising edge after rst deasserts.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Priority per edge: flush > stall > capture.
  - flush: wb_valid=0, wb_regwrite=0. wb_data and wb_rd are don't-care; the implementation holds them. Counter is not incremented.
  - stall (flush=0): all outputs and the counter hold.
  - capture:
    - wb_valid=in_valid.
    - wb_regwrite=in_valid & in_regwrite & ~(ZERO_GUARD & in_rd==0).
    - wb_rd=in_rd.
    - wb_data=selected value.
    - retired_count increments when in_valid=1.
- Load alignment when in_wb_sel=01, off=in_alu_result[1:0]:
  - Word: in_read_data unchanged; off is ignored (no misalignment trap in this block).
  - Half: lane chosen by off[1]; off[0] is ignored. BIG_ENDIAN=1 gives off[1]=0 → [31:16] and off[1]=1 → [15:0]; BIG_ENDIAN=0 reverses the lanes.
  - Byte: BIG_ENDIAN=1 gives lane [31-8*off -: 8]; BIG_ENDIAN=0 gives lane [8*off +: 8].
  - Extension: sign-extend from bit 15 (half) or bit 7 (byte) unless in_load_unsigned=1, which zero-extends.
- in_load_size and in_load_unsigned are ignored unless in_wb_sel=01.
- retired_count wraps from 2^COUNT_W-1 to 0 silently.
- No combinational path from any input to any output.

Decomposition:
- Shared package/header holds:
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_LINK=2'b10.
  - LD_WORD=2'b00, LD_HALF=2'b01, LD_BYTE=2'b10.
  - The associated 2-bit typedefs.
- One natural combinational sub-module, load_align: inputs raw word, offset, size, unsigned flag, BIG_ENDIAN; output the extended 32-bit value. It is instantiated once, ahead of the 3:1 select.

Test Plan:
- Reset mid-run: assert rst asynchronously between edges with retired_count=7 → all outputs read 0 immediately, before the next edge.
- ALU/link select: in_valid=1, in_regwrite=1, rd=8.
  - wb_sel=00, alu=0x0000_1234 → next cycle wb_data=0x0000_1234, wb_rd=8, wb_regwrite=1.
  - wb_sel=10, link=0x0040_0010 → wb_data=0x0040_0010.
  - wb_sel=11 → ALU value selected.
- Sub-word loads, BIG_ENDIAN=1, read_data=0x80F1_7F02:
  - lb off=0 → 0xFFFF_FF80.
  - lbu off=0 → 0x0000_0080.
  - lb off=2 → 0x0000_007F.
  - lh off=2 → 0x0000_7F02.
  - lh off=0 → 0xFFFF_80F1.
  - lhu off=0 → 0x0000_80F1.
- $0 guard: in_rd=0, in_regwrite=1, in_valid=1 → wb_regwrite=0, wb_valid=1, retired_count increments.
- Stall/flush interaction:
  - stall=1 for 3 cycles with changing inputs → outputs and count frozen.
  - stall=1 and flush=1 together → wb_valid=0, wb_regwrite=0, count unchanged.
- Counter wrap: COUNT_W=4, retire 17 valid instructions with 3 bubbles (in_valid=0) interleaved → retired_count=1.
